// File: rtl/md_sequencer.sv
// md_sequencer: iterative signed multiply / restoring divide sequencer feeding
// REG_HIGH/REG_LOW. One iteration per clock on operand magnitudes, followed by
// a sign-fix cycle. Optional build macro MD_UNSIGNED_EN adds input op_unsigned
// (MULTU/DIVU: no sign handling, same latency).
module md_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
`ifdef MD_UNSIGNED_EN
    input  logic             op_unsigned,
`endif
    input  logic             abort,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             hilo_we,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_FIX, S_DONE, S_DZ} state_t;

    state_t               state, state_nxt;
    logic                 op_r;
    logic                 neg_a, neg_b;
    logic [WIDTH-1:0]     m_r;
    logic [WIDTH-1:0]     acc;
    logic [WIDTH-1:0]     q;
    logic [CW-1:0]        count;

    logic                 is_signed;
    logic                 a_neg_in, b_neg_in;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH-1:0]     div_diff;
    logic                 div_ok;
    logic [2*WIDTH-1:0]   prod, prod_fix;
    logic [WIDTH-1:0]     quot_fix, rem_fix;

`ifdef MD_UNSIGNED_EN
    assign is_signed = ~op_unsigned;
`else
    assign is_signed = 1'b1;
`endif

    // Operand magnitudes and sign capture at request time
    always_comb begin
        a_neg_in = is_signed & a[WIDTH-1];
        b_neg_in = is_signed & b[WIDTH-1];
        mag_a    = a_neg_in ? (~a + 1'b1) : a;
        mag_b    = b_neg_in ? (~b + 1'b1) : b;
    end

    // One shift-add / restoring-divide step and the final sign correction
    always_comb begin
        // acc is the upper product half (MULT) or the partial remainder (DIV);
        // q is the multiplier being consumed (MULT) or dividend becoming quotient (DIV)
        mul_sum   = {1'b0, acc} + (q[0] ? {1'b0, m_r} : '0);
        div_shift = {acc, q[WIDTH-1]};
        div_ok    = (div_shift >= {1'b0, m_r});
        // Remainder after subtraction is below the divisor, so the low W bits suffice
        div_diff  = div_shift[WIDTH-1:0] - m_r;
        prod      = {acc, q};
        prod_fix  = (neg_a ^ neg_b) ? (~prod + 1'b1) : prod;
        quot_fix  = (neg_a ^ neg_b) ? (~q + 1'b1) : q;
        rem_fix   = neg_a ? (~acc + 1'b1) : acc;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        hilo_we   = 1'b0;
        div_zero  = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start && !abort)
                    state_nxt = (op && (b == '0)) ? S_DZ : S_RUN;
            end
            S_RUN: begin
                if (abort)                          state_nxt = S_IDLE;
                else if (count == CW'(WIDTH - 1))   state_nxt = S_FIX;
            end
            S_FIX:  state_nxt = abort ? S_IDLE : S_DONE;
            S_DONE: begin
                done      = 1'b1;
                hilo_we   = 1'b1;
                state_nxt = S_IDLE;
            end
            S_DZ: begin
                done      = 1'b1;
                div_zero  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: operand latch, iteration registers and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r  <= 1'b0;
            neg_a <= 1'b0;
            neg_b <= 1'b0;
            m_r   <= '0;
            acc   <= '0;
            q     <= '0;
            count <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        op_r  <= op;
                        neg_a <= a_neg_in;
                        neg_b <= b_neg_in;
                        m_r   <= mag_b;
                        q     <= mag_a;
                        acc   <= '0;
                        count <= '0;
                    end
                end
                S_RUN: begin
                    if (!abort) begin
                        count <= count + CW'(1);
                        if (!op_r) begin
                            {acc, q} <= {mul_sum, q[WIDTH-1:1]};
                        end else begin
                            acc <= div_ok ? div_diff : div_shift[WIDTH-1:0];
                            q   <= {q[WIDTH-2:0], div_ok};
                        end
                    end
                end
                S_FIX: begin
                    // Results land on the FIX->DONE edge so hi/lo change only on entry to DONE
                    if (!abort) begin
                        if (op_r) begin
                            hi <= rem_fix;
                            lo <= quot_fix;
                        end else begin
                            {hi, lo} <= prod_fix;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_md_sequencer.sv
// tb_md_sequencer: directed and random checks of md_sequencer against a
// plain-arithmetic reference (64-bit signed multiply, truncating divide).
module tb_md_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        op;
`ifdef MD_UNSIGNED_EN
    logic        op_unsigned;
`endif
    logic        abort;
    logic [31:0] a, b;
    logic        busy, done, hilo_we, div_zero;
    logic [31:0] hi, lo;

    int tests = 0;
    int fails = 0;

    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    localparam int LAT = 33; // clock edges from the start edge to the first done cycle

    md_sequencer #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
`ifdef MD_UNSIGNED_EN
        .op_unsigned(op_unsigned),
`endif
        .abort(abort), .a(a), .b(b),
        .busy(busy), .done(done), .hilo_we(hilo_we), .div_zero(div_zero),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference: signed product / truncating quotient, remainder signed like dividend
    task automatic model(input logic o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] rh, output logic [31:0] rl);
        longint sx, sy, r;
        logic [63:0] v;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (!o) begin
            v  = 64'(sx * sy);
            rh = v[63:32];
            rl = v[31:0];
        end else begin
            r  = sx / sy;
            v  = 64'(r);
            rl = v[31:0];
            r  = sx % sy;
            v  = 64'(r);
            rh = v[31:0];
        end
    endtask

    // Present a request for one edge, then scramble the operand inputs
    task automatic launch(input logic o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom;
    endtask

    task automatic finish_op(input string tag, input logic o, input logic [31:0] x, input logic [31:0] y);
        int n;
        logic dz;
        logic [31:0] rh, rl;
        n  = 0;
        dz = o && (y == 32'd0);
        while (done !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, ".latency"}, 64'(n), dz ? 64'd0 : 64'(LAT));
        if (dz) begin
            chk({tag, ".div_zero"}, 64'(div_zero), 64'd1);
            chk({tag, ".hilo_we"}, 64'(hilo_we), 64'd0);
        end else begin
            model(o, x, y, rh, rl);
            exp_hi = rh;
            exp_lo = rl;
            chk({tag, ".div_zero"}, 64'(div_zero), 64'd0);
            chk({tag, ".hilo_we"}, 64'(hilo_we), 64'd1);
        end
        chk({tag, ".hi"}, 64'(hi), 64'(exp_hi));
        chk({tag, ".lo"}, 64'(lo), 64'(exp_lo));
        @(posedge clk); #1;
        chk({tag, ".busy_after"}, 64'(busy), 64'd0);
        chk({tag, ".done_after"}, 64'(done), 64'd0);
    endtask

    task automatic do_op(input string tag, input logic o, input logic [31:0] x, input logic [31:0] y);
        launch(o, x, y);
        finish_op(tag, o, x, y);
    endtask

    initial begin
        int n;
        logic seen;
        logic o;
        logic [31:0] x, y;
        rst = 1'b1; start = 1'b0; op = 1'b0; abort = 1'b0; a = '0; b = '0;
`ifdef MD_UNSIGNED_EN
        op_unsigned = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("reset.busy", 64'(busy), 64'd0);
        chk("reset.done", 64'(done), 64'd0);
        chk("reset.hilo_we", 64'(hilo_we), 64'd0);
        chk("reset.div_zero", 64'(div_zero), 64'd0);
        chk("reset.hi", 64'(hi), 64'd0);
        chk("reset.lo", 64'(lo), 64'd0);
        @(negedge clk); rst = 1'b0;

        do_op("mult_7_m3", 1'b0, 32'd7, 32'hFFFF_FFFD);
        chk("mult_7_m3.hi_const", 64'(exp_hi), 64'hFFFF_FFFF);
        do_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        chk("div_m7_2.lo_const", 64'(exp_lo), 64'hFFFF_FFFD);
        do_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE);
        do_op("div_by_zero", 1'b1, 32'd5, 32'd0);
        do_op("div_minint_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op("mult_minint_sq", 1'b0, 32'h8000_0000, 32'h8000_0000);

        // start re-pulsed mid-run (as a DIV by zero) must be ignored
        launch(1'b0, 32'd1234, 32'hFFFF_0001);
        repeat (5) @(posedge clk);
        #1; start = 1'b1; op = 1'b1; b = 32'd0;
        @(posedge clk); #1; start = 1'b0;
        n = 0; seen = 1'b0;
        while (done !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
        chk("restart_ignored.latency", 64'(n + 6), 64'(LAT));
        chk("restart_ignored.div_zero", 64'(div_zero), 64'd0);
        model(1'b0, 32'd1234, 32'hFFFF_0001, exp_hi, exp_lo);
        chk("restart_ignored.lo", 64'(lo), 64'(exp_lo));
        repeat (3) begin @(posedge clk); #1; if (done === 1'b1) seen = 1'b1; end
        chk("restart_ignored.single_done", 64'(seen), 64'd0);

        // abort during RUN
        launch(1'b0, 32'd99, 32'd77);
        repeat (9) @(posedge clk);
        #1; abort = 1'b1;
        @(posedge clk); #1; abort = 1'b0;
        chk("abort_run.busy", 64'(busy), 64'd0);
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (done === 1'b1) seen = 1'b1; end
        chk("abort_run.no_done", 64'(seen), 64'd0);
        chk("abort_run.hi", 64'(hi), 64'(exp_hi));
        chk("abort_run.lo", 64'(lo), 64'(exp_lo));

        // abort during FIX: the last cycle before results would be written
        launch(1'b1, 32'd1000, 32'd7);
        repeat (LAT - 1) @(posedge clk);
        #1;
        chk("abort_fix.busy_before", 64'(busy), 64'd1);
        abort = 1'b1;
        @(posedge clk); #1; abort = 1'b0;
        chk("abort_fix.busy", 64'(busy), 64'd0);
        chk("abort_fix.done", 64'(done), 64'd0);
        chk("abort_fix.hi", 64'(hi), 64'(exp_hi));
        chk("abort_fix.lo", 64'(lo), 64'(exp_lo));

        // abort together with start in IDLE drops the request
        @(negedge clk); start = 1'b1; abort = 1'b1; op = 1'b0; a = 32'd3; b = 32'd3;
        @(posedge clk); #1; start = 1'b0; abort = 1'b0;
        chk("abort_start.busy", 64'(busy), 64'd0);

        // asynchronous reset mid-run
        launch(1'b0, 32'd12345, 32'd6789);
        repeat (12) @(posedge clk);
        #1; rst = 1'b1; #1;
        chk("rst_mid.busy", 64'(busy), 64'd0);
        chk("rst_mid.done", 64'(done), 64'd0);
        chk("rst_mid.hi", 64'(hi), 64'd0);
        chk("rst_mid.lo", 64'(lo), 64'd0);
        exp_hi = '0; exp_lo = '0;
        @(negedge clk); rst = 1'b0;
        do_op("mult_after_rst", 1'b0, 32'h0001_0000, 32'h0001_0000);
        chk("mult_after_rst.hi_const", 64'(exp_hi), 64'd1);

        // random operations, with occasional zero divisors and extreme operands
        for (int i = 0; i < 24; i++) begin
            o = 1'($urandom_range(0, 1));
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 7))
                0: y = 32'd0;
                1: x = 32'h8000_0000;
                2: y = 32'h7FFF_FFFF;
                3: y = 32'($urandom_range(1, 9));
                default: ;
            endcase
            do_op($sformatf("rand%0d", i), o, x, y);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
